// File: rtl/ltl_monitor_sequencer.sv
// ltl_monitor_sequencer
//   Front-end controller for one LTL automaton cluster. It round-robin
//   arbitrates NREQ trace-symbol sources onto the cluster's single 8-bit
//   symbol port, sequences a monitoring session (clear, arm, run, drain) and
//   folds the cluster's report outputs into a sticky violation record.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_sym     per-requester symbol offer (symbol i at [8*i+7:8*i])
//   req_ready             one-hot grant, combinational
//   sess_start/sess_stop  session control pulses
//   mon_reset/mon_run     cluster reset / run enables (registered)
//   mon_symbols           symbol presented to the cluster (registered)
//   mon_report            cluster report bits, one cycle behind the symbol
//   busy                  session in CLEAR/ARM/RUN/DRAIN
//   viol/viol_mask        sticky violation flag / OR of report bits seen
//   viol_idx              index of the symbol that produced the first violation
//   sym_count             symbols consumed this session, saturating
module ltl_monitor_sequencer #(
    parameter int NREQ         = 2,
    parameter int REPORT_W     = 4,
    parameter int CNT_W        = 16,
    parameter int RST_CYCLES   = 2,
    parameter int STOP_ON_VIOL = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*8-1:0]     req_sym,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  sess_start,
    input  logic                  sess_stop,
    output logic                  mon_reset,
    output logic                  mon_run,
    output logic [7:0]            mon_symbols,
    input  logic [REPORT_W-1:0]   mon_report,
    output logic                  busy,
    output logic                  viol,
    output logic [REPORT_W-1:0]   viol_mask,
    output logic [CNT_W-1:0]      viol_idx,
    output logic [CNT_W-1:0]      sym_count
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CLR_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ARM,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   rr_ptr;
    logic [CLR_W-1:0]   clr_cnt;
    logic               clr_done;
    logic               start_ok;
    logic               grant_en;
    logic               found;
    logic               gnt_any;
    logic [PTR_W-1:0]   gnt_idx;
    logic [7:0]         gnt_sym;
    logic               run_p1;
    logic [CNT_W-1:0]   idx_p0;
    logic [CNT_W-1:0]   idx_p1;
    logic               viol_hit;
    logic               viol_stop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NREQ - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A report is only meaningful for a cycle in which the cluster consumed a symbol.
    assign viol_hit  = run_p1 && (mon_report != '0);
    assign viol_stop = (STOP_ON_VIOL != 0) && viol_hit;
    assign start_ok  = sess_start && ((state == S_IDLE) || (state == S_DONE));
    assign clr_done  = (clr_cnt == CLR_W'(RST_CYCLES - 1));
    assign grant_en  = ((state == S_ARM) || (state == S_RUN)) && !sess_stop && !viol_stop;
    assign busy      = (state == S_CLEAR) || (state == S_ARM) ||
                       (state == S_RUN)   || (state == S_DRAIN);

    // Round-robin search: first pass from the pointer upward, second pass wraps below it.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && (i >= int'(rr_ptr)) && req_valid[i]) begin
                found   = 1'b1;
                gnt_idx = PTR_W'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && (i < int'(rr_ptr)) && req_valid[i]) begin
                found   = 1'b1;
                gnt_idx = PTR_W'(i);
            end
        end
        gnt_any   = grant_en && found;
        req_ready = '0;
        gnt_sym   = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = gnt_any && (gnt_idx == PTR_W'(i));
            if (gnt_idx == PTR_W'(i)) begin
                gnt_sym = req_sym[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (sess_start) state_nxt = S_CLEAR;
            S_CLEAR: begin
                if (sess_stop)     state_nxt = S_DONE;
                else if (clr_done) state_nxt = S_ARM;
            end
            S_ARM: begin
                if (sess_stop)    state_nxt = S_DONE;
                else if (gnt_any) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (viol_stop)      state_nxt = S_DONE;
                else if (sess_stop) state_nxt = S_DRAIN;
            end
            S_DRAIN: state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            clr_cnt     <= '0;
            mon_reset   <= 1'b1;
            mon_run     <= 1'b0;
            mon_symbols <= '0;
            run_p1      <= 1'b0;
            viol        <= 1'b0;
            viol_mask   <= '0;
            viol_idx    <= '0;
            sym_count   <= '0;
        end else begin
            state     <= state_nxt;
            clr_cnt   <= (state == S_CLEAR) ? clr_cnt + CLR_W'(1) : '0;
            // The cluster leaves reset on the same edge that delivers its first symbol.
            mon_reset <= (state_nxt == S_IDLE) || (state_nxt == S_CLEAR) ||
                         (state_nxt == S_ARM);
            // p0 -> p1: symbol on the port this cycle, its report arrives next cycle.
            mon_run   <= gnt_any;
            run_p1    <= mon_run;
            if (gnt_any) begin
                mon_symbols <= gnt_sym;
                rr_ptr      <= ptr_next(gnt_idx);
            end
            if (start_ok) begin
                viol      <= 1'b0;
                viol_mask <= '0;
                viol_idx  <= '0;
                sym_count <= '0;
            end else begin
                if (viol_hit) begin
                    viol      <= 1'b1;
                    viol_mask <= viol_mask | mon_report;
                    if (!viol) viol_idx <= idx_p1;
                end
                if (gnt_any) sym_count <= sat_inc(sym_count);
            end
        end
    end

    // Symbol index travels with the symbol: p0 at the port, p1 alongside its report.
    always_ff @(posedge clk) begin
        if (gnt_any) idx_p0 <= sym_count;
        idx_p1 <= idx_p0;
    end

endmodule

// File: tb/tb_ltl_monitor_sequencer.sv
// tb_ltl_monitor_sequencer
//   Directed bench for ltl_monitor_sequencer. Instance dut_s ends the session on
//   the first violation; instance dut_a keeps running and accumulates reports.
//   Both share the stimulus; each scenario checks the instance it targets.
module tb_ltl_monitor_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [15:0] req_sym = '0;
    logic        sess_start = 1'b0;
    logic        sess_stop = 1'b0;
    logic [3:0]  mon_report = '0;

    logic [1:0]  ready_s, ready_a;
    logic        mreset_s, mreset_a, run_s, run_a, busy_s, busy_a, viol_s, viol_a;
    logic [7:0]  sym_s, sym_a;
    logic [3:0]  mask_s, mask_a;
    logic [15:0] idx_s, idx_a, cnt_s, cnt_a;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ltl_monitor_sequencer #(.NREQ(2), .REPORT_W(4), .CNT_W(16), .RST_CYCLES(2), .STOP_ON_VIOL(1)) dut_s (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_sym(req_sym), .req_ready(ready_s),
        .sess_start(sess_start), .sess_stop(sess_stop), .mon_reset(mreset_s), .mon_run(run_s),
        .mon_symbols(sym_s), .mon_report(mon_report), .busy(busy_s), .viol(viol_s),
        .viol_mask(mask_s), .viol_idx(idx_s), .sym_count(cnt_s));

    ltl_monitor_sequencer #(.NREQ(2), .REPORT_W(4), .CNT_W(16), .RST_CYCLES(2), .STOP_ON_VIOL(0)) dut_a (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_sym(req_sym), .req_ready(ready_a),
        .sess_start(sess_start), .sess_stop(sess_stop), .mon_reset(mreset_a), .mon_run(run_a),
        .mon_symbols(sym_a), .mon_report(mon_report), .busy(busy_a), .viol(viol_a),
        .viol_mask(mask_a), .viol_idx(idx_a), .sym_count(cnt_a));

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; req_valid = '0; req_sym = '0;
        sess_start = 1'b0; sess_stop = 1'b0; mon_report = '0;
        cyc; cyc;
        reset = 1'b0;
    endtask

    task automatic start_session;
        sess_start = 1'b1;
        cyc;
        sess_start = 1'b0;
    endtask

    task automatic test_reset;
        logic [23:0] exp_ctl;
        reset = 1'b1; req_valid = 2'b11; sess_start = 1'b1; mon_report = 4'hF;
        cyc; cyc; #1;
        exp_ctl = {1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 4'h0, 6'h0};
        vectors++;
        if ({mreset_s, run_s, sym_s, ready_s, busy_s, viol_s, mask_s, 6'h0} !== exp_ctl) begin
            miscompares++;
            $display("FAIL reset_ctl_s: got %h want %h", {mreset_s, run_s, sym_s, ready_s, busy_s, viol_s, mask_s, 6'h0}, exp_ctl);
        end
        vectors++;
        if ({idx_s, cnt_s} !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_cnt_s: got idx=%h cnt=%h want 0/0", idx_s, cnt_s);
        end
        vectors++;
        if ({mreset_a, run_a, sym_a, ready_a, busy_a, viol_a, mask_a, 6'h0} !== exp_ctl) begin
            miscompares++;
            $display("FAIL reset_ctl_a: got %h want %h", {mreset_a, run_a, sym_a, ready_a, busy_a, viol_a, mask_a, 6'h0}, exp_ctl);
        end
    endtask

    task automatic test_first_symbol;
        do_reset;
        req_valid = 2'b01; req_sym = 16'h0005; sess_start = 1'b1; #1;
        vectors++;
        if ({ready_s, mreset_s, busy_s} !== {2'b00, 1'b1, 1'b0}) begin
            miscompares++; $display("FAIL first_idle: got %b want 0010", {ready_s, mreset_s, busy_s});
        end
        cyc; sess_start = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            vectors++;
            if ({ready_s, mreset_s, busy_s, run_s} !== {2'b00, 1'b1, 1'b1, 1'b0}) begin
                miscompares++; $display("FAIL first_clear%0d: got %b want 00110", c, {ready_s, mreset_s, busy_s, run_s});
            end
            cyc;
        end
        #1;
        vectors++;
        if ({ready_s, mreset_s, busy_s, run_s} !== {2'b01, 1'b1, 1'b1, 1'b0}) begin
            miscompares++; $display("FAIL first_arm: got %b want 01110", {ready_s, mreset_s, busy_s, run_s});
        end
        cyc; req_valid = 2'b00; #1;
        vectors++;
        if ({sym_s, mreset_s, run_s, cnt_s, ready_s} !== {8'h05, 1'b0, 1'b1, 16'd1, 2'b00}) begin
            miscompares++; $display("FAIL first_run: got sym=%h rst=%b run=%b cnt=%0d rdy=%b want 05/0/1/1/00", sym_s, mreset_s, run_s, cnt_s, ready_s);
        end
        cyc; #1;
        vectors++;
        if ({run_s, busy_s} !== 2'b01) begin
            miscompares++; $display("FAIL first_nodata: got run=%b busy=%b want 0/1", run_s, busy_s);
        end
        sess_stop = 1'b1;
        cyc; sess_stop = 1'b0; #1;
        vectors++;
        if ({busy_s, run_s, mreset_s} !== 3'b100) begin
            miscompares++; $display("FAIL first_drain: got %b want 100", {busy_s, run_s, mreset_s});
        end
        cyc; #1;
        vectors++;
        if ({busy_s, run_s, mreset_s, cnt_s} !== {3'b000, 16'd1}) begin
            miscompares++; $display("FAIL first_done: got busy=%b run=%b rst=%b cnt=%0d want 0/0/0/1", busy_s, run_s, mreset_s, cnt_s);
        end
    endtask

    task automatic test_round_robin;
        logic [7:0] es;
        logic [1:0] er;
        do_reset;
        req_valid = 2'b11; req_sym = 16'h0201;
        start_session; cyc; cyc; #1;
        vectors++;
        if (ready_s !== 2'b01) begin
            miscompares++; $display("FAIL rr_arm: got %b want 01", ready_s);
        end
        for (int k = 0; k < 4; k++) begin
            cyc;
            if (k == 3) req_valid = 2'b00;
            #1;
            es = (k % 2 == 0) ? 8'h01 : 8'h02;
            er = (k == 3) ? 2'b00 : ((k % 2 == 0) ? 2'b10 : 2'b01);
            vectors++;
            if ({sym_s, run_s, cnt_s, ready_s} !== {es, 1'b1, 16'(k + 1), er}) begin
                miscompares++;
                $display("FAIL rr_step%0d: got sym=%h run=%b cnt=%0d rdy=%b want %h/1/%0d/%b", k, sym_s, run_s, cnt_s, ready_s, es, k + 1, er);
            end
        end
    endtask

    task automatic test_stop_on_viol;
        do_reset;
        req_valid = 2'b11; req_sym = 16'h0201;
        start_session; cyc; cyc;
        cyc; cyc; cyc; #1;
        vectors++;
        if ({sym_s, run_s} !== {8'h01, 1'b1}) begin
            miscompares++; $display("FAIL sv_third_sym: got sym=%h run=%b want 01/1", sym_s, run_s);
        end
        cyc; mon_report = 4'b0100; #1;
        vectors++;
        if (ready_s !== 2'b00) begin
            miscompares++; $display("FAIL sv_suppress: got %b want 00", ready_s);
        end
        cyc; mon_report = 4'b0000; #1;
        vectors++;
        if ({viol_s, mask_s, idx_s, busy_s, run_s, cnt_s} !== {1'b1, 4'b0100, 16'd2, 1'b0, 1'b0, 16'd4}) begin
            miscompares++;
            $display("FAIL sv_done: got viol=%b mask=%b idx=%0d busy=%b run=%b cnt=%0d want 1/0100/2/0/0/4", viol_s, mask_s, idx_s, busy_s, run_s, cnt_s);
        end
        cyc; #1;
        vectors++;
        if ({ready_s, mreset_s, cnt_s, idx_s} !== {2'b00, 1'b0, 16'd4, 16'd2}) begin
            miscompares++; $display("FAIL sv_hold: got rdy=%b rst=%b cnt=%0d idx=%0d want 00/0/4/2", ready_s, mreset_s, cnt_s, idx_s);
        end
    endtask

    task automatic test_accumulate;
        do_reset;
        req_valid = 2'b11; req_sym = 16'h0201;
        start_session; cyc; cyc;
        for (int k = 1; k <= 7; k++) begin
            cyc;
            mon_report = (k == 3) ? 4'b0001 : ((k == 6) ? 4'b1000 : 4'b0000);
            #1;
            if (k == 4) begin
                vectors++;
                if ({viol_a, mask_a, idx_a} !== {1'b1, 4'b0001, 16'd1}) begin
                    miscompares++; $display("FAIL acc_first: got viol=%b mask=%b idx=%0d want 1/0001/1", viol_a, mask_a, idx_a);
                end
            end
            if (k == 7) begin
                vectors++;
                if ({viol_a, mask_a, idx_a, busy_a, run_a, cnt_a} !== {1'b1, 4'b1001, 16'd1, 1'b1, 1'b1, 16'd7}) begin
                    miscompares++;
                    $display("FAIL acc_second: got viol=%b mask=%b idx=%0d busy=%b run=%b cnt=%0d want 1/1001/1/1/1/7", viol_a, mask_a, idx_a, busy_a, run_a, cnt_a);
                end
            end
        end
        mon_report = 4'b0000;
    endtask

    task automatic test_gaps;
        do_reset;
        req_valid = 2'b01; req_sym = 16'h0005;
        start_session; cyc; cyc; cyc;
        req_valid = 2'b00; #1;
        vectors++;
        if (run_s !== 1'b1) begin
            miscompares++; $display("FAIL gap_r1: got run=%b want 1", run_s);
        end
        for (int k = 2; k <= 6; k++) begin
            cyc;
            if (k == 4) req_valid = 2'b01;
            mon_report = (k >= 3 && k <= 5) ? 4'hF : 4'h0;
            #1;
            vectors++;
            if ({run_s, viol_s} !== {(k >= 5), 1'b0}) begin
                miscompares++; $display("FAIL gap_r%0d: got run=%b viol=%b want %b/0", k, run_s, viol_s, (k >= 5));
            end
        end
        cyc; mon_report = 4'h0; #1;
        vectors++;
        if ({viol_s, mask_s, busy_s} !== {1'b0, 4'h0, 1'b1}) begin
            miscompares++; $display("FAIL gap_ignored: got viol=%b mask=%b busy=%b want 0/0000/1", viol_s, mask_s, busy_s);
        end
    endtask

    task automatic test_stop_arm;
        do_reset;
        start_session; cyc; cyc; #1;
        vectors++;
        if ({busy_s, ready_s, mreset_s} !== {1'b1, 2'b00, 1'b1}) begin
            miscompares++; $display("FAIL arm_wait: got %b want 1001", {busy_s, ready_s, mreset_s});
        end
        sess_stop = 1'b1;
        cyc; sess_stop = 1'b0; req_valid = 2'b01; #1;
        vectors++;
        if ({busy_s, run_s, mreset_s, ready_s, cnt_s} !== {3'b000, 2'b00, 16'd0}) begin
            miscompares++; $display("FAIL arm_stop: got busy=%b run=%b rst=%b rdy=%b cnt=%0d want 0/0/0/00/0", busy_s, run_s, mreset_s, ready_s, cnt_s);
        end
        sess_start = 1'b1; sess_stop = 1'b1;
        cyc; sess_start = 1'b0; sess_stop = 1'b0; #1;
        vectors++;
        if ({busy_s, mreset_s, ready_s} !== {2'b11, 2'b00}) begin
            miscompares++; $display("FAIL done_start_wins: got busy=%b rst=%b rdy=%b want 1/1/00", busy_s, mreset_s, ready_s);
        end
    endtask

    task automatic test_reset_mid_run;
        do_reset;
        req_valid = 2'b11; req_sym = 16'h0201;
        start_session; cyc; cyc; cyc; cyc; #1;
        vectors++;
        if ({run_s, cnt_s} !== {1'b1, 16'd2}) begin
            miscompares++; $display("FAIL mid_pre: got run=%b cnt=%0d want 1/2", run_s, cnt_s);
        end
        reset = 1'b1; mon_report = 4'hF;
        cyc; #1;
        vectors++;
        if ({mreset_s, run_s, sym_s, ready_s, busy_s, viol_s, mask_s, idx_s, cnt_s} !==
            {1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 4'h0, 16'd0, 16'd0}) begin
            miscompares++;
            $display("FAIL mid_reset: got rst=%b run=%b sym=%h rdy=%b busy=%b viol=%b mask=%b idx=%0d cnt=%0d want all reset values",
                     mreset_s, run_s, sym_s, ready_s, busy_s, viol_s, mask_s, idx_s, cnt_s);
        end
        reset = 1'b0;
        cyc; mon_report = 4'h0; #1;
        vectors++;
        if ({viol_s, mask_s, busy_s, cnt_s} !== {1'b0, 4'h0, 1'b0, 16'd0}) begin
            miscompares++; $display("FAIL mid_after: got viol=%b mask=%b busy=%b cnt=%0d want 0/0000/0/0", viol_s, mask_s, busy_s, cnt_s);
        end
    endtask

    initial begin
        test_reset;
        test_first_symbol;
        test_round_robin;
        test_stop_on_viol;
        test_accumulate;
        test_gaps;
        test_stop_arm;
        test_reset_mid_run;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

endmodule
